// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift sequencer: state encoding and the
// default word width.
package shift_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_reg_lr.sv
// Parallel-load, right-shifting register; the serial input enters the MSB.
// Load has priority over shift.
module shift_reg_lr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_serial,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {i_serial, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial frame sequencer: accepts a parallel word, shifts it out LSB first
// while assembling the received word, then holds the result until consumed.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | ready for a new word; serial lines quiet
//   ST_SHIFT | one bit out / one bit in per cycle, WIDTH cycles in total
//   ST_DONE  | received word presented on out_data until out_ready
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             shift_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_shreg;

  shift_reg_lr #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_data(in_data),
    .i_shift    (w_shift),
    .i_serial   (serial_in),
    .o_q        (w_shreg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    in_ready    = 1'b0;
    shift_en    = 1'b0;
    serial_out  = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en   = 1'b1;
        busy       = 1'b1;
        serial_out = w_shreg[0];
        w_shift    = 1'b1;
        w_cnt_nxt  = r_cnt + CW'(1);
        // Counter tops out at WIDTH on the last edge, so it never wraps.
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out_data = w_shreg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: stimulus pushes expected words, a
// negedge monitor pops and compares on every out_valid/out_ready handshake.
module tb_shift_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         serial_in;
  logic         serial_out;
  logic         shift_en;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         busy;

  logic         loopback = 1'b1;
  logic         drv_bit = 1'b0;
  logic [W-1:0] ser_word = '0;
  int           sh_idx = 0;

  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] exp_tx_q[$];
  logic [W-1:0] tx_seen = '0;
  int           tx_n = 0;
  int           done_cyc = -1;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_od = '0;
  logic         auto_rdy = 1'b0;

  always #5 clk = ~clk;

  assign serial_in = loopback ? serial_out : drv_bit;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .serial_in (serial_in),
    .serial_out(serial_out),
    .shift_en  (shift_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Serial source for non-loopback frames: bit j of ser_word in SHIFT cycle j.
  always @(negedge clk) begin
    if (shift_en) begin
      drv_bit = (sh_idx < W) ? ser_word[sh_idx] : 1'b0;
      sh_idx++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (auto_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor
  always @(negedge clk) begin
    logic [W-1:0] e_rx;
    logic [W-1:0] e_tx;
    if (reset) begin
      chk("ready_iff_idle", {31'd0, in_ready}, {31'd0, !busy});
      if (!shift_en) chk("serial_quiet", {31'd0, serial_out}, 32'd0);
      chk("valid_not_in_shift", {31'd0, shift_en & out_valid}, 32'd0);
      if (out_valid && prev_hold) chk("done_hold", {28'd0, out_data}, {28'd0, prev_od});
      if (shift_en) begin
        if (tx_n < W) tx_seen[tx_n] = serial_out;
        tx_n++;
      end
      if (out_valid && out_ready) begin
        done_cyc = cyc + 1;
        if (exp_rx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: got out_data %0h expected no frame", out_data);
        end else begin
          e_rx = exp_rx_q.pop_front();
          e_tx = exp_tx_q.pop_front();
          chk("rx_word", {28'd0, out_data}, {28'd0, e_rx});
          chk("tx_bits", {28'd0, tx_seen}, {28'd0, e_tx});
          chk("frame_len", tx_n, W);
        end
        tx_n = 0;
      end
    end
    prev_hold = reset && out_valid && !out_ready;
    prev_od   = out_data;
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [W-1:0] d, input logic lb, input logic [W-1:0] sw);
    wait_ready();
    loopback = lb;
    ser_word = sw;
    sh_idx   = 0;
    in_data  = d;
    in_valid = 1'b1;
    exp_tx_q.push_back(d);
    exp_rx_q.push_back(lb ? d : sw);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_reached", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic release_done();
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_serial_out"}, {31'd0, serial_out}, 32'd0);
    chk({tag, "_shift_en"}, {31'd0, shift_en}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {28'd0, out_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic flush_sb();
    exp_rx_q.delete();
    exp_tx_q.delete();
    tx_n = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] sw;
    logic         lb;
    int           acc_edge;
    int           t;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    // Idle with in_valid low
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_serial_out", {31'd0, serial_out}, 32'd0);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Loopback 1010 with exact latency
    d = 4'b1010;
    loopback = 1'b1;
    in_data  = d;
    in_valid = 1'b1;
    exp_tx_q.push_back(d);
    exp_rx_q.push_back(d);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("lat_shift_en", {31'd0, shift_en}, 32'd1);
      chk("lat_serial_bit", {31'd0, serial_out}, {31'd0, d[i]});
    end
    @(negedge clk);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_data", {28'd0, out_data}, {28'd0, d});
    release_done();

    // Driven serial_in 1,1,1,0 with in_data 0 -> 0111
    send(4'b0000, 1'b0, 4'b0111);
    wait_done();
    chk("driven_out_data", {28'd0, out_data}, 32'h7);
    release_done();

    // DONE held without out_ready; in_valid with 1111 must be ignored
    send(4'b0110, 1'b1, 4'b0000);
    wait_done();
    in_valid = 1'b1;
    in_data  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_data", {28'd0, out_data}, 32'h6);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("after_hold_idle", {31'd0, in_ready}, 32'd1);
    chk("after_hold_busy", {31'd0, busy}, 32'd0);

    // Reset on the 2nd SHIFT cycle aborts the frame
    send(4'b1101, 1'b1, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'b1011;
    @(posedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b0;
    flush_sb();
    @(negedge clk);
    check_reset_vals("abort_shift");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // Reset in DONE wins over out_ready on the same edge
    send(4'b1001, 1'b1, 4'b0000);
    wait_done();
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b0;
    flush_sb();
    @(negedge clk);
    check_reset_vals("abort_done");

    // Two frames with in_valid held high and out_ready high
    wait_ready();
    loopback  = 1'b1;
    in_data   = 4'b1110;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    exp_tx_q.push_back(4'b1110);
    exp_rx_q.push_back(4'b1110);
    @(posedge clk);
    #1 in_data = 4'b0011;
    exp_tx_q.push_back(4'b0011);
    exp_rx_q.push_back(4'b0011);
    t = 0;
    @(negedge clk);
    while (!(in_valid && in_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    acc_edge = cyc + 1;
    chk("b2b_accept_gap", acc_edge, done_cyc + 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done();
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("b2b_both_popped", exp_rx_q.size(), 0);

    // Randomized frames
    auto_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d  = W'($urandom);
      sw = W'($urandom);
      lb = 1'($urandom_range(0, 1));
      send(d, lb, sw);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    t = 0;
    while (exp_rx_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain", exp_rx_q.size(), 0);
    auto_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
